fifo_uart_tx: RTL and testbench

Serial transmitter that drains a flip-flop-based small FIFO and shifts each byte out as an asynchronous 8N1 UART frame (LSB first). It sits on the FIFO's read side, producing single-cycle, never-back-to-back read strobes and consuming the registered data/valid pair one cycle later. It prefetches the next word during the stop bit, so consecutive frames leave no idle gap.

---
 rtl/fifo_uart_pkg.sv | 19 +
 rtl/fifo_uart_tx_baud_timer.sv | 27 ++
 rtl/fifo_uart_tx.sv | 212 +++++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared state encoding and constants for the FIFO-draining UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to the encoding.
package fifo_uart_pkg;

    localparam int BIT_CNT_W = 4;
    localparam int MIN_DIV   = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_START   = 3'd2,
        ST_DATA    = 3'd3,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY  = 3'd5,
`endif
        ST_STOP    = 3'd4
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_baud_timer.sv
// Loadable bit-time down-counter; tick marks the last clock of each bit.
module baud_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // Reloads itself at terminal count so consecutive bits need no explicit load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || (cnt == '0)) begin
            cnt <= div - 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a registered-output FIFO and serialises each word as an async UART frame, LSB first.
// Define FIFO_UART_TX_PARITY_EN for a parity bit between data and stop (adds input parity_odd).
//
// state   | meaning
// IDLE    | line high, waiting for enable and a non-empty FIFO
// RD_WAIT | read strobe out, waiting for the registered FIFO word
// START   | start bit, tx low
// DATA    | data bits, LSB first
// PARITY  | parity bit (parity builds only)
// STOP    | stop bit; next word is prefetched here
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  baud_div,
`ifdef FIFO_UART_TX_PARITY_EN
    input  logic                  parity_odd,
`endif
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] next_data_q, next_data_d;
    logic                  next_vld_q, next_vld_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  div_clamped, timer_div;
    logic                  rd_pend_q;
    logic                  fifo_read_d;
    logic                  tx_d;
    logic                  timer_load;
    logic                  tick;
    logic                  load_word;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  rd_hit;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif

    assign div_clamped = (baud_div < MIN_DIV_W) ? MIN_DIV_W : baud_div;
    assign timer_div   = timer_load ? div_clamped : div_q;
    // The FIFO word is only trusted in the cycle right after our own strobe.
    assign rd_hit      = rd_pend_q && fifo_data_valid;

    baud_timer #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .div  (timer_div),
        .tick (tick)
    );

    always_comb begin
        state_d     = state;
        shift_d     = shift_q;
        next_data_d = next_data_q;
        next_vld_d  = next_vld_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        fifo_read_d = 1'b0;
        timer_load  = 1'b0;
        load_word   = 1'b0;
        load_data   = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d       = par_q;
`endif

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_read_d = 1'b1;
                    state_d     = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rd_pend_q) begin
                    if (fifo_data_valid) begin
                        load_word = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (next_vld_q) begin
                        load_word  = 1'b1;
                        load_data  = next_data_q;
                        next_vld_d = 1'b0;
                    end else if (rd_hit) begin
                        load_word = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rd_hit) begin
                    next_data_d = fifo_data;
                    next_vld_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobe lands on the first stop-bit cycle so the word is back before the bit ends.
        if ((state_d == ST_STOP) && (state != ST_STOP) && !fifo_empty) begin
            fifo_read_d = 1'b1;
        end

        if (load_word) begin
            state_d    = ST_START;
            shift_d    = load_data;
            div_d      = div_clamped;
            timer_load = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d      = (^load_data) ^ parity_odd;
`endif
        end

        if (!enable) begin
            state_d     = ST_IDLE;
            next_vld_d  = 1'b0;
            fifo_read_d = 1'b0;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            next_data_q <= '0;
            next_vld_q  <= 1'b0;
            bit_cnt_q   <= '0;
            div_q       <= '0;
            rd_pend_q   <= 1'b0;
            fifo_read   <= 1'b0;
            tx          <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            shift_q     <= shift_d;
            next_data_q <= next_data_d;
            next_vld_q  <= next_vld_d;
            bit_cnt_q   <= bit_cnt_d;
            div_q       <= div_d;
            rd_pend_q   <= fifo_read && enable;
            fifo_read   <= fifo_read_d;
            tx          <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign busy    = (state != ST_IDLE);
    assign tx_done = (state == ST_STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames, a monitor decodes tx and compares.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] baud_div;
    logic        fifo_empty;
    logic        fifo_read;
    logic [7:0]  fifo_data;
    logic        fifo_data_valid;
    logic        tx;
    logic        busy;
    logic        tx_done;
`ifdef FIFO_UART_TX_PARITY_EN
    logic        parity_odd;
`endif

    typedef struct {
        logic [7:0] data;
        int         div;
        int         trunc;
        int         gap;
        bit         has_par;
        bit         par;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    int         adj_cnt = 0;
    int         done_cnt = 0;
    bit         force_ne = 1'b0;

    fifo_uart_tx #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .baud_div        (baud_div),
`ifdef FIFO_UART_TX_PARITY_EN
        .parity_odd      (parity_odd),
`endif
        .fifo_empty      (fifo_empty),
        .fifo_read       (fifo_read),
        .fifo_data       (fifo_data),
        .fifo_data_valid (fifo_data_valid),
        .tx              (tx),
        .busy            (busy),
        .tx_done         (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int div, input int gap,
                                input int trunc, input bit has_par, input bit par);
        exp_t it;
        it.data = d; it.div = div; it.gap = gap; it.trunc = trunc;
        it.has_par = has_par; it.par = par;
        exp_q.push_back(it);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({"idle_", name}, int'(n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_fall(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({"fall_", name}, int'(n < 500), 1);
    endtask

    // Registered-output FIFO: word and valid appear one cycle after the strobe.
    initial begin : fifo_model
        logic rd_seen;
        fifo_empty = 1'b1;
        fifo_data_valid = 1'b0;
        fifo_data = 8'h00;
        forever begin
            @(negedge clk);
            rd_seen = (fifo_read === 1'b1);
            @(posedge clk);
            #1;
            if (rst) begin
                fifo_data_valid = 1'b0;
            end else if (rd_seen && fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                fifo_data_valid = 1'b1;
            end else begin
                fifo_data_valid = 1'b0;
            end
            fifo_empty = (fifo_q.size() == 0) && !force_ne;
        end
    end

    initial begin : strobe_monitor
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_read === 1'b1) begin
                rd_cnt++;
                if (prev) adj_cnt++;
            end
            prev = (fifo_read === 1'b1);
            if (tx_done === 1'b1) done_cnt++;
        end
    end

    initial begin : frame_monitor
        int since_end;
        exp_t it;
        int nbits, total, n, bad_bit, bad_done, bad_busy, k;
        logic [10:0] bits;
        logic [7:0] rx;
        since_end = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                since_end = 0;
            end else if (tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: tx low with no frame queued (t=%0t)", $time);
                    k = 0;
                    while (tx === 1'b0 && k < 200) begin
                        @(negedge clk);
                        k++;
                    end
                end else begin
                    it = exp_q.pop_front();
                    nbits = it.has_par ? 11 : 10;
                    bits = '1;
                    bits[0] = 1'b0;
                    bits[8:1] = it.data;
                    if (it.has_par) bits[9] = it.par;
                    total = nbits * it.div;
                    n = (it.trunc > 0) ? it.trunc : total;
                    bad_bit = 0; bad_done = 0; bad_busy = 0; rx = 8'h00;
                    for (int c = 0; c < n; c++) begin
                        if (c > 0) @(negedge clk);
                        k = c / it.div;
                        if (tx !== bits[k]) bad_bit++;
                        if (tx_done !== (c == total - 1)) bad_done++;
                        if (busy !== 1'b1) bad_busy++;
                        if ((c % it.div) == (it.div / 2) && k >= 1 && k <= 8) rx[k-1] = tx;
                    end
                    check("frame_bits", bad_bit, 0);
                    check("frame_tx_done", bad_done, 0);
                    check("frame_busy", bad_busy, 0);
                    if (it.trunc == 0) check("frame_data", int'(rx), int'(it.data));
                    if (it.gap >= 0) check("frame_gap", since_end, it.gap);
                end
                since_end = 0;
            end else begin
                since_end++;
                if (tx_done === 1'b1) begin
                    errors++;
                    $display("FAIL stray_tx_done: tx_done=1 outside a frame (t=%0t)", $time);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int r0, d0, lows, n;
        rst = 1'b1;
        enable = 1'b0;
        baud_div = 16'd4;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_fifo_read", int'(fifo_read), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_done", int'(tx_done), 0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // single byte 0xA5 at div 4
        r0 = rd_cnt; d0 = done_cnt;
        expect_frame(8'hA5, 4, -1, 0, 0, 0);
        fifo_q.push_back(8'hA5);
        wait_idle("single");
        check("single_reads", rd_cnt - r0, 1);
        check("single_done", done_cnt - d0, 1);
        check("single_busy", int'(busy), 0);

        // burst of three, back to back at div 3
        baud_div = 16'd3;
        r0 = rd_cnt; d0 = done_cnt;
        expect_frame(8'h01, 3, -1, 0, 0, 0);
        expect_frame(8'h02, 3, 0, 0, 0, 0);
        expect_frame(8'h03, 3, 0, 0, 0, 0);
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
        wait_idle("burst");
        check("burst_reads", rd_cnt - r0, 3);
        check("burst_done", done_cnt - d0, 3);

        // prefetch miss: second word arrives during the last stop cycle
        baud_div = 16'd4;
        r0 = rd_cnt;
        expect_frame(8'h3C, 4, -1, 0, 0, 0);
        expect_frame(8'hC3, 4, 3, 0, 0, 0);
        fifo_q.push_back(8'h3C);
        n = 0;
        while (tx_done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("miss_done_seen", int'(n < 500), 1);
        fifo_q.push_back(8'hC3);
        wait_idle("miss");
        check("miss_reads", rd_cnt - r0, 2);

        // empty race: flag says non-empty but no word comes back
        r0 = rd_cnt; d0 = done_cnt;
        force_ne = 1'b1;
        n = 0;
        while (fifo_read !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        force_ne = 1'b0;
        check("race_read_seen", int'(n < 50), 1);
        lows = 0;
        repeat (12) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("race_reads", rd_cnt - r0, 1);
        check("race_tx_high", lows, 0);
        check("race_done", done_cnt - d0, 0);
        check("race_busy", int'(busy), 0);

        // abort during data bit 3 of 0x55
        d0 = done_cnt;
        expect_frame(8'h55, 4, -1, 17, 0, 0);
        fifo_q.push_back(8'h55);
        wait_fall("abort");
        repeat (16) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        repeat (8) @(negedge clk);
        check("abort_done", done_cnt - d0, 0);
        enable = 1'b1;
        repeat (4) @(negedge clk);

        // abort after prefetch captured: prefetched word must never be sent
        r0 = rd_cnt; d0 = done_cnt;
        expect_frame(8'h11, 4, -1, 39, 0, 0);
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        wait_fall("pf_abort");
        repeat (38) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("pf_abort_tx", int'(tx), 1);
        check("pf_abort_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        expect_frame(8'h33, 4, -1, 0, 0, 0);
        fifo_q.push_back(8'h33);
        wait_idle("pf_abort");
        repeat (60) @(negedge clk);
        check("pf_abort_reads", rd_cnt - r0, 3);
        check("pf_abort_done", done_cnt - d0, 1);

        // divisor 0 and 1 behave as 2
        baud_div = 16'd0;
        expect_frame(8'h96, 2, -1, 0, 0, 0);
        fifo_q.push_back(8'h96);
        wait_idle("div0");
        baud_div = 16'd1;
        expect_frame(8'h69, 2, -1, 0, 0, 0);
        fifo_q.push_back(8'h69);
        wait_idle("div1");

        // divisor change mid-frame applies from the next start bit
        baud_div = 16'd4;
        expect_frame(8'hC0, 4, -1, 0, 0, 0);
        expect_frame(8'h0C, 2, 0, 0, 0, 0);
        fifo_q.push_back(8'hC0); fifo_q.push_back(8'h0C);
        wait_fall("div_change");
        repeat (10) @(negedge clk);
        baud_div = 16'd2;
        wait_idle("div_change");

`ifdef FIFO_UART_TX_PARITY_EN
        baud_div = 16'd4;
        parity_odd = 1'b0;
        expect_frame(8'h07, 4, -1, 0, 1, 1);
        fifo_q.push_back(8'h07);
        wait_idle("par_even");
        parity_odd = 1'b1;
        expect_frame(8'h07, 4, -1, 0, 1, 0);
        fifo_q.push_back(8'h07);
        wait_idle("par_odd");
`endif

        // reset mid-frame drives the line high without waiting for a clock
        baud_div = 16'd4;
        expect_frame(8'hF0, 4, -1, 6, 0, 0);
        fifo_q.push_back(8'hF0);
        wait_fall("async_rst");
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tx", int'(tx), 1);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_read", int'(fifo_read), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_tx", int'(tx), 1);

        check("read_adjacent", adj_cnt, 0);
        check("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
